front_detector: RTL and testbench

Synchronous edge detector for a single-bit or multi-bit level input: flags rising, falling and any transitions of `in` relative to its value at the previous `clk` edge. It is a generic utility block placed after an input synchronizer or register stage. It feeds pulse-driven logic such as counters, interrupt sources and FSM triggers. Optional internal synchronizer and output register stages let it sit directly on asynchronous pins.

---
 rtl/front_detector_pkg.sv | 12 +
 rtl/front_sync.sv | 37 +++
 rtl/front_detector.sv | 99 +++++++++
 tb/tb_front_detector.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/front_detector_pkg.sv
// Shared constants and helpers for the front_detector edge-detection block.
package front_detector_pkg;

    // Deepest synchronizer chain the block supports in front of the detector.
    localparam int MaxSyncStages = 3;

    // True when a WIDTH / SYNC_STAGES combination is one the block can build.
    function automatic bit paramsLegal(input int width, input int syncStages);
        return (width >= 1) && (syncStages >= 0) && (syncStages <= MaxSyncStages);
    endfunction

endpackage

// File: rtl/front_sync.sv
// WIDTH-wide, STAGES-deep flip-flop synchronizer with asynchronous reset to 0.
module front_sync
    import front_detector_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // A zero-stage chain has no meaning here; the parent bypasses this module instead.
    if (STAGES < 1 || STAGES > MaxSyncStages) begin : gBadStages
        $error("front_sync: STAGES must be 1..%0d", MaxSyncStages);
    end

    // Shift the sampled input down the chain one stage per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int k = 1; k < STAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/front_detector.sv
// Per-bit rising/falling/any edge detector with optional input synchronizer
// and optional output register. A priming flag suppresses the first compare
// after reset so the post-reset input level becomes the baseline.
module front_detector
    import front_detector_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 0,
    parameter int REG_OUT     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] pos_edge_o,
    output logic [WIDTH-1:0] neg_edge_o,
    output logic [WIDTH-1:0] any_edge_o
);

    logic [WIDTH-1:0] syncOut;
    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] hist_d;
    logic             primed_q;
    logic             primed_d;
    logic [WIDTH-1:0] detPos;
    logic [WIDTH-1:0] detNeg;
    logic [WIDTH-1:0] detAny;

    if (!paramsLegal(WIDTH, SYNC_STAGES)) begin : gBadParams
        $error("front_detector: need WIDTH >= 1 and SYNC_STAGES in 0..%0d", MaxSyncStages);
    end

    // Either bring the input through a synchronizer or use it as-is.
    if (SYNC_STAGES > 0) begin : gSync
        front_sync #(
            .WIDTH  (WIDTH),
            .STAGES (SYNC_STAGES)
        ) uSync (
            .clk   (clk),
            .rst_n (rst_n),
            .d_i   (in_i),
            .q_o   (syncOut)
        );
    end else begin : gNoSync
        assign syncOut = in_i;
    end

    // History always tracks the synchronized input; priming latches high for good.
    always_comb begin
        hist_d   = syncOut;
        primed_d = 1'b1;
    end

    // History and priming registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q   <= '0;
            primed_q <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            primed_q <= primed_d;
        end
    end

    // Each bit compares its current level against the previous one.
    for (genvar i = 0; i < WIDTH; i++) begin : gBit
        assign detPos[i] = primed_q &  syncOut[i] & ~hist_q[i];
        assign detNeg[i] = primed_q & ~syncOut[i] &  hist_q[i];
        assign detAny[i] = primed_q & (syncOut[i] ^ hist_q[i]);
    end

    // Optionally retime the flags; reset clears them without waiting for a clock.
    if (REG_OUT != 0) begin : gRegOut
        logic [WIDTH-1:0] posEdge_q;
        logic [WIDTH-1:0] negEdge_q;
        logic [WIDTH-1:0] anyEdge_q;

        // Output flag registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                posEdge_q <= '0;
                negEdge_q <= '0;
                anyEdge_q <= '0;
            end else begin
                posEdge_q <= detPos;
                negEdge_q <= detNeg;
                anyEdge_q <= detAny;
            end
        end

        assign pos_edge_o = posEdge_q;
        assign neg_edge_o = negEdge_q;
        assign any_edge_o = anyEdge_q;
    end else begin : gCombOut
        assign pos_edge_o = detPos;
        assign neg_edge_o = detNeg;
        assign any_edge_o = detAny;
    end

endmodule

// File: tb/tb_front_detector.sv
// Directed bench for front_detector: default build, a synchronized and
// registered build, and a 4-bit build share one clock and reset.
module tb_front_detector;

    logic       clk;
    logic       rst_n;
    logic       inA;
    logic       inS;
    logic [3:0] inB;

    logic       posA, negA, anyA;
    logic       posS, negS, anyS;
    logic [3:0] posB, negB, anyB;

    int checks = 0;
    int errors = 0;

    // Single-bit sequence and its hand-derived flags for the default build.
    bit [0:18] seqV = 19'b0101000001110000000;
    bit [0:18] posV = 19'b0101000001000000000;
    bit [0:18] negV = 19'b0010100000001000000;

    front_detector #(.WIDTH(1), .SYNC_STAGES(0), .REG_OUT(0)) d0 (
        .clk(clk), .rst_n(rst_n), .in_i(inA),
        .pos_edge_o(posA), .neg_edge_o(negA), .any_edge_o(anyA)
    );

    front_detector #(.WIDTH(1), .SYNC_STAGES(2), .REG_OUT(1)) d1 (
        .clk(clk), .rst_n(rst_n), .in_i(inS),
        .pos_edge_o(posS), .neg_edge_o(negS), .any_edge_o(anyS)
    );

    front_detector #(.WIDTH(4), .SYNC_STAGES(0), .REG_OUT(0)) d2 (
        .clk(clk), .rst_n(rst_n), .in_i(inB),
        .pos_edge_o(posB), .neg_edge_o(negB), .any_edge_o(anyB)
    );

    // Free-running clock, semiperiod 10.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Change inputs just after a rising edge, then settle to mid-cycle for checks.
    task automatic applyStimulus(input logic a, input logic s, input logic [3:0] b);
        @(posedge clk);
        #1;
        inA = a;
        inS = s;
        inB = b;
        #4;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Directed sequence.
    initial begin
        rst_n = 1'b0;
        inA   = 1'bx;
        inS   = 1'b0;
        inB   = 4'bxxxx;
        #5;
        checkOutput("reset_anyA", {3'b0, anyA}, 4'b0000);
        checkOutput("reset_anyS", {3'b0, anyS}, 4'b0000);
        checkOutput("reset_anyB", anyB, 4'b0000);

        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        inA   = 1'b1;
        inB   = 4'b0000;
        #4;
        checkOutput("unprimed_anyA", {3'b0, anyA}, 4'b0000);
        checkOutput("unprimed_anyB", anyB, 4'b0000);

        // Priming edge: in=1 becomes the baseline, no pulse.
        applyStimulus(1'b1, 1'b0, 4'b0000);
        checkOutput("prime_anyA", {3'b0, anyA}, 4'b0000);
        checkOutput("prime_posA", {3'b0, posA}, 4'b0000);
        checkOutput("prime_hist", {3'b0, d0.hist_q}, 4'b0001);
        checkOutput("prime_anyB", anyB, 4'b0000);

        // A later change is reported.
        applyStimulus(1'b0, 1'b0, 4'b0000);
        checkOutput("after_prime_negA", {3'b0, negA}, 4'b0001);
        checkOutput("after_prime_posA", {3'b0, posA}, 4'b0000);

        // Shared single-bit sequence; the sync+reg build lags by 3 cycles.
        for (int i = 0; i < 19; i++) begin
            applyStimulus(seqV[i], seqV[i], 4'b0000);
            checkOutput($sformatf("seq%0d_posA", i), {3'b0, posA}, {3'b0, posV[i]});
            checkOutput($sformatf("seq%0d_negA", i), {3'b0, negA}, {3'b0, negV[i]});
            checkOutput($sformatf("seq%0d_anyA", i), {3'b0, anyA}, {3'b0, posV[i] | negV[i]});
            checkOutput($sformatf("seq%0d_exclA", i), {3'b0, posA & negA}, 4'b0000);
            if (i >= 3) begin
                checkOutput($sformatf("seq%0d_posS", i), {3'b0, posS}, {3'b0, posV[i-3]});
                checkOutput($sformatf("seq%0d_negS", i), {3'b0, negS}, {3'b0, negV[i-3]});
                checkOutput($sformatf("seq%0d_anyS", i), {3'b0, anyS}, {3'b0, posV[i-3] | negV[i-3]});
            end else begin
                checkOutput($sformatf("seq%0d_anyS", i), {3'b0, anyS}, 4'b0000);
            end
        end

        // 4-bit vector changes.
        applyStimulus(1'b0, 1'b0, 4'b1010);
        checkOutput("w4_first_pos", posB, 4'b1010);
        checkOutput("w4_first_neg", negB, 4'b0000);
        checkOutput("w4_first_any", anyB, 4'b1010);
        applyStimulus(1'b0, 1'b0, 4'b0110);
        checkOutput("w4_second_pos", posB, 4'b0100);
        checkOutput("w4_second_neg", negB, 4'b1000);
        checkOutput("w4_second_any", anyB, 4'b1100);
        applyStimulus(1'b0, 1'b0, 4'b0110);
        checkOutput("w4_hold_any", anyB, 4'b0000);

        // Reset in the middle of a pulse.
        applyStimulus(1'b1, 1'b0, 4'b1111);
        checkOutput("midpulse_posA", {3'b0, posA}, 4'b0001);
        checkOutput("midpulse_anyB", anyB, 4'b1001);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_posA", {3'b0, posA}, 4'b0000);
        checkOutput("async_rst_anyA", {3'b0, anyA}, 4'b0000);
        checkOutput("async_rst_anyB", anyB, 4'b0000);
        checkOutput("async_rst_anyS", {3'b0, anyS}, 4'b0000);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #4;
        checkOutput("rerelease_anyA", {3'b0, anyA}, 4'b0000);
        checkOutput("rerelease_anyB", anyB, 4'b0000);
        applyStimulus(1'b1, 1'b0, 4'b1111);
        checkOutput("reprime_anyA", {3'b0, anyA}, 4'b0000);
        checkOutput("reprime_anyB", anyB, 4'b0000);
        checkOutput("reprime_primed", {3'b0, d0.primed_q}, 4'b0001);
        applyStimulus(1'b0, 1'b0, 4'b1110);
        checkOutput("post_reprime_negA", {3'b0, negA}, 4'b0001);
        checkOutput("post_reprime_negB", negB, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
